// File: rtl/hs_npu_pkg.sv
// Shared types for the NPU matrix-multiply control path.
//   uword          : 32-bit unsigned word used for gatekeeper cycle counts
//   mm_seq_state_t : matrix-multiply sequencer FSM states
package hs_npu_pkg;

   typedef logic [31:0] uword;

   typedef enum logic [3:0] {
      StIdle,
      StFlush,
      StLoadW,
      StShiftW,
      StLoadIn,
      StStart,
      StWaitOut,
      StDrain,
      StDone
   } mm_seq_state_t;

endpackage

// File: rtl/hs_npu_mm_sequencer_if.sv
// Handshake/control bundle between the matrix-multiply sequencer and its surroundings.
//   slave  : sequencer side (job/push/status inputs, FIFO/gatekeeper controls out)
//   master : job source / matrix-multiply unit side
interface hs_npu_mm_sequencer_if #(
   parameter int unsigned CNT_W = 16
);
   import hs_npu_pkg::*;

   logic             job_valid_i;
   logic             job_ready_o;
   logic [CNT_W-1:0] job_rows_i;
   logic             job_reuse_w_i;
   logic             abort_i;
   logic             weight_push_i;
   logic             input_push_i;
   logic             last_col_valid_i;
   logic             weight_load_en_o;
   logic             input_load_en_o;
   logic             flush_weight_fifos_o;
   logic             flush_input_fifos_o;
   logic             enable_weights_o;
   logic             start_input_gatekeeper_o;
   logic             start_output_gatekeeper_o;
   uword             enable_cycles_o;
   logic             busy_o;
   logic             done_o;
   logic             err_o;

   modport slave (
      input  job_valid_i, job_rows_i, job_reuse_w_i, abort_i,
      input  weight_push_i, input_push_i, last_col_valid_i,
      output job_ready_o, weight_load_en_o, input_load_en_o,
      output flush_weight_fifos_o, flush_input_fifos_o, enable_weights_o,
      output start_input_gatekeeper_o, start_output_gatekeeper_o,
      output enable_cycles_o, busy_o, done_o, err_o
   );

   modport master (
      output job_valid_i, job_rows_i, job_reuse_w_i, abort_i,
      output weight_push_i, input_push_i, last_col_valid_i,
      input  job_ready_o, weight_load_en_o, input_load_en_o,
      input  flush_weight_fifos_o, flush_input_fifos_o, enable_weights_o,
      input  start_input_gatekeeper_o, start_output_gatekeeper_o,
      input  enable_cycles_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/hs_npu_mm_seq_counter.sv
// Loadable down-counter with zero flag; saturates at zero.
//   clk, rst   : clock, async active-high reset
//   load_i     : load load_val_i (wins over dec_i)
//   dec_i      : decrement by one unless already zero
//   zero_o     : count is zero
module hs_npu_mm_seq_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/hs_npu_mm_sequencer.sv
// Sequences one matrix-multiply job: FIFO flush, weight load/shift, input load, then the
// input and output gatekeeper start pulses spaced ARRAY_LATENCY cycles apart, and finally
// completion once the last output column has gone valid and dropped again.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of hs_npu_mm_sequencer_if (job handshake, push strobes,
//              last-column valid in; FIFO/gatekeeper controls and status out)
// All outputs are registered from the next state, so they track the current state.
module hs_npu_mm_sequencer #(
   parameter int unsigned SIZE             = 8,
   parameter int unsigned INPUT_FIFO_DEPTH = 10,
   parameter int unsigned ARRAY_LATENCY    = 9,
   parameter int unsigned CNT_W            = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   hs_npu_mm_sequencer_if.slave bus
);
   import hs_npu_pkg::*;

   mm_seq_state_t    state_q, state_d;
   logic [CNT_W-1:0] rows_q, rows_d;
   logic             reuse_q, reuse_d;
   logic             seen_high_q, seen_high_d;
   logic             abort_now, job_bad;

   logic ready_q, busy_q, wl_q, il_q, fw_q, fi_q, ew_q, si_q, so_q, done_q, err_q;
   logic ready_d, busy_d, wl_d, il_d, fw_d, fi_d, ew_d, si_d, so_d, done_d, err_d;

   logic w_load, w_dec, w_zero;
   logic s_load, s_dec, s_zero;
   logic i_load, i_dec, i_zero;
   logic t_load, t_dec, t_zero;

   assign job_bad = (bus.job_rows_i == '0) || (bus.job_rows_i > CNT_W'(INPUT_FIFO_DEPTH));

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      reuse_d     = reuse_q;
      seen_high_d = seen_high_q;
      err_d       = 1'b0;
      abort_now   = 1'b0;

      if ((state_q != StIdle) && bus.abort_i) begin
         state_d   = StIdle;
         abort_now = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               // abort_i in IDLE blocks acceptance without raising err_o
               if (bus.job_valid_i && ready_q && !bus.abort_i) begin
                  if (job_bad) begin
                     err_d = 1'b1;
                  end else begin
                     rows_d  = bus.job_rows_i;
                     reuse_d = bus.job_reuse_w_i;
                     state_d = StFlush;
                  end
               end
            end
            StFlush:   state_d = reuse_q ? StLoadIn : StLoadW;
            StLoadW:   if (bus.weight_push_i && w_zero) state_d = StShiftW;
            StShiftW:  if (s_zero) state_d = StLoadIn;
            StLoadIn:  if (bus.input_push_i && i_zero) state_d = StStart;
            StStart:   state_d = StWaitOut;
            StWaitOut: if (t_zero) state_d = StDrain;
            StDrain: begin
               if (seen_high_q && !bus.last_col_valid_i) begin
                  state_d = StDone;
               end else if (bus.last_col_valid_i) begin
                  seen_high_d = 1'b1;
               end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
         endcase
      end

      if (state_d != StDrain) seen_high_d = 1'b0;
   end

   // Counters are loaded with (terminal count - 1) on state entry so that the zero flag
   // marks the final push/cycle. The wait counter also runs during START, which makes the
   // start_in -> start_out spacing exactly ARRAY_LATENCY.
   assign w_load = (state_d == StLoadW) && (state_q != StLoadW);
   assign w_dec  = (state_q == StLoadW) && bus.weight_push_i;
   assign s_load = (state_d == StShiftW) && (state_q != StShiftW);
   assign s_dec  = (state_q == StShiftW);
   assign i_load = (state_d == StLoadIn) && (state_q != StLoadIn);
   assign i_dec  = (state_q == StLoadIn) && bus.input_push_i;
   assign t_load = (state_d == StStart) && (state_q != StStart);
   assign t_dec  = (state_q == StStart) || (state_q == StWaitOut);

   hs_npu_mm_seq_counter #(.CNT_W(CNT_W)) u_weight_cnt (
      .clk(clk), .rst(rst), .load_i(w_load), .load_val_i(CNT_W'(SIZE - 1)),
      .dec_i(w_dec), .zero_o(w_zero)
   );

   hs_npu_mm_seq_counter #(.CNT_W(CNT_W)) u_shift_cnt (
      .clk(clk), .rst(rst), .load_i(s_load), .load_val_i(CNT_W'(SIZE - 1)),
      .dec_i(s_dec), .zero_o(s_zero)
   );

   hs_npu_mm_seq_counter #(.CNT_W(CNT_W)) u_input_cnt (
      .clk(clk), .rst(rst), .load_i(i_load), .load_val_i(rows_q - CNT_W'(1)),
      .dec_i(i_dec), .zero_o(i_zero)
   );

   hs_npu_mm_seq_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk(clk), .rst(rst), .load_i(t_load), .load_val_i(CNT_W'(ARRAY_LATENCY - 1)),
      .dec_i(t_dec), .zero_o(t_zero)
   );

   always_comb begin
      ready_d = (state_d == StIdle);
      busy_d  = (state_d != StIdle);
      wl_d    = (state_d == StLoadW);
      il_d    = (state_d == StLoadIn);
      ew_d    = (state_d == StShiftW);
      si_d    = (state_d == StStart);
      so_d    = (state_q == StWaitOut) && (state_d == StDrain);
      done_d  = (state_d == StDone);
      fi_d    = (state_d == StFlush) || abort_now;
      fw_d    = ((state_d == StFlush) && !reuse_d) || abort_now;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         rows_q      <= '0;
         reuse_q     <= 1'b0;
         seen_high_q <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         wl_q        <= 1'b0;
         il_q        <= 1'b0;
         fw_q        <= 1'b0;
         fi_q        <= 1'b0;
         ew_q        <= 1'b0;
         si_q        <= 1'b0;
         so_q        <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         reuse_q     <= reuse_d;
         seen_high_q <= seen_high_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         wl_q        <= wl_d;
         il_q        <= il_d;
         fw_q        <= fw_d;
         fi_q        <= fi_d;
         ew_q        <= ew_d;
         si_q        <= si_d;
         so_q        <= so_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign bus.job_ready_o               = ready_q;
   assign bus.busy_o                    = busy_q;
   assign bus.weight_load_en_o          = wl_q;
   assign bus.input_load_en_o           = il_q;
   assign bus.flush_weight_fifos_o      = fw_q;
   assign bus.flush_input_fifos_o       = fi_q;
   assign bus.enable_weights_o          = ew_q;
   assign bus.start_input_gatekeeper_o  = si_q;
   assign bus.start_output_gatekeeper_o = so_q;
   assign bus.done_o                    = done_q;
   assign bus.err_o                     = err_q;
   assign bus.enable_cycles_o           = uword'(rows_q);

endmodule

// File: tb/tb_hs_npu_mm_sequencer.sv
// Self-checking bench for hs_npu_mm_sequencer (SIZE=4, depth 10, latency 9).
// The reference is a per-job timeline: from the push/valid schedule the bench computes,
// with plain arithmetic, the slot in which each phase starts and ends, and compares the
// full output vector every cycle. Slot n is sampled 1 time unit after clock edge n, where
// edge 0 is the edge that accepts the job.
module tb_hs_npu_mm_sequencer;

   localparam int unsigned SIZE  = 4;
   localparam int unsigned DEPTH = 10;
   localparam int unsigned LAT   = 9;
   localparam int unsigned CNT_W = 16;

   // {ready, busy, wload, iload, wflush, iflush, enw, start_in, start_out, done, err}
   localparam logic [10:0] IDLE_V = 11'b100_0000_0000;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   last_rows = 0;

   always #5 clk = ~clk;

   hs_npu_mm_sequencer_if #(.CNT_W(CNT_W)) bus_if ();

   hs_npu_mm_sequencer #(
      .SIZE(SIZE), .INPUT_FIFO_DEPTH(DEPTH), .ARRAY_LATENCY(LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus_if)
   );

   function automatic logic [10:0] obs();
      return {bus_if.job_ready_o, bus_if.busy_o, bus_if.weight_load_en_o,
              bus_if.input_load_en_o, bus_if.flush_weight_fifos_o, bus_if.flush_input_fifos_o,
              bus_if.enable_weights_o, bus_if.start_input_gatekeeper_o,
              bus_if.start_output_gatekeeper_o, bus_if.done_o, bus_if.err_o};
   endfunction

   function automatic logic [10:0] pack(input logic r, b, wl, il, fw, fi, ew, si, so, dn, er);
      return {r, b, wl, il, fw, fi, ew, si, so, dn, er};
   endfunction

   task automatic clear_inputs();
      bus_if.job_valid_i      = 1'b0;
      bus_if.job_rows_i       = '0;
      bus_if.job_reuse_w_i    = 1'b0;
      bus_if.abort_i          = 1'b0;
      bus_if.weight_push_i    = 1'b0;
      bus_if.input_push_i     = 1'b0;
      bus_if.last_col_valid_i = 1'b0;
   endtask

   // gfix>0 : fixed push spacing, else random 1..3. extra: stray pushes outside load windows.
   // abort_at: -1 none, -2 random slot, else slot in which abort_i is driven.
   // rst_at: -1 none, else slot after which rst is asserted asynchronously (left asserted).
   task automatic run_job(input int rows, input bit reuse, input int gfix, input bit extra,
                          input int vdelay, input int vhigh, input int abort_in,
                          input int rst_at, input string name);
      int we[SIZE];
      int ie[16];
      int e, g, ws, a, s, p, ds, last, abort_at;
      bit wp, ip, busy_e;
      logic [10:0] exp_v, act;

      e = 1;
      ws = 0;
      a = 1;
      if (!reuse) begin
         for (int k = 0; k < int'(SIZE); k++) begin
            g = (gfix > 0) ? gfix : int'($urandom_range(3, 1));
            e += g;
            we[k] = e;
         end
         ws = we[SIZE-1];
         a  = ws + int'(SIZE);
      end
      e = a;
      for (int k = 0; k < rows; k++) begin
         g = (gfix > 0) ? gfix : int'($urandom_range(3, 1));
         e += g;
         ie[k] = e;
      end
      s  = ie[rows-1];
      p  = s + int'(LAT) + vdelay;
      ds = p + vhigh + 1;
      abort_at = (abort_in == -2) ? int'($urandom_range(ds, 0)) : abort_in;
      last = (abort_at >= 0) ? abort_at + 4 : ((rst_at >= 0) ? rst_at : ds + 1);

      bus_if.job_valid_i   = 1'b1;
      bus_if.job_rows_i    = CNT_W'(rows);
      bus_if.job_reuse_w_i = reuse;

      for (int n = 0; n <= last; n++) begin
         @(posedge clk);
         #1;
         bus_if.job_valid_i = 1'b0;
         if ((abort_at >= 0) && (n > abort_at)) begin
            exp_v = (n == abort_at + 1) ? pack(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0) : IDLE_V;
         end else begin
            busy_e = (n <= ds);
            exp_v = pack(!busy_e, busy_e, !reuse && n >= 1 && n < ws, n >= a && n < s,
                         n == 0 && !reuse, n == 0, !reuse && n >= ws && n < ws + int'(SIZE),
                         n == s, n == s + int'(LAT), n == ds, 1'b0);
         end
         act = obs();
         checks++;
         if (act !== exp_v) begin
            errors++;
            $display("FAIL %s slot %0d: outputs got %b want %b", name, n, act, exp_v);
         end
         if (n == 0) begin
            last_rows = rows;
            checks++;
            if (bus_if.enable_cycles_o !== 32'(rows)) begin
               errors++;
               $display("FAIL %s enable_cycles: got %0d want %0d", name,
                        bus_if.enable_cycles_o, rows);
            end
         end
         if ((rst_at >= 0) && (n == rst_at)) begin
            #2 rst = 1'b1;
            #1;
            act = obs();
            checks++;
            if (((act & 11'h3FF) !== 11'h000) || (bus_if.enable_cycles_o !== 32'd0)) begin
               errors++;
               $display("FAIL %s async_rst: outputs got %b enc %0d want 0", name, act,
                        bus_if.enable_cycles_o);
            end
            last_rows = 0;
         end else begin
            wp = 1'b0;
            ip = 1'b0;
            if (!reuse) for (int k = 0; k < int'(SIZE); k++) if (we[k] == n + 1) wp = 1'b1;
            for (int k = 0; k < rows; k++) if (ie[k] == n + 1) ip = 1'b1;
            if (extra) begin
               if ((n == 0) || (!reuse && ((n == ws) || (n == ws + 1)))) wp = 1'b1;
               if ((n == 0) || (n == s)) ip = 1'b1;
            end
            bus_if.last_col_valid_i = (n >= p) && (n < p + vhigh);
            bus_if.abort_i          = (n == abort_at);
            if ((abort_at >= 0) && (n > abort_at)) begin
               wp = 1'b0;
               ip = 1'b0;
               bus_if.last_col_valid_i = 1'b0;
            end
            bus_if.weight_push_i = wp;
            bus_if.input_push_i  = ip;
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      logic [10:0] act;
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      act = obs();
      checks++;
      if ((act & 11'h3FF) !== 11'h000) begin
         errors++;
         $display("FAIL reset_hold: outputs got %b want 0 (ready ignored)", act);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      act = obs();
      checks++;
      if ((act !== IDLE_V) || (bus_if.enable_cycles_o !== 32'd0)) begin
         errors++;
         $display("FAIL reset_release: outputs got %b enc %0d want %b enc 0", act,
                  bus_if.enable_cycles_o, IDLE_V);
      end
   endtask

   task automatic test_reject(input int rows);
      logic [10:0] act;
      bus_if.job_valid_i = 1'b1;
      bus_if.job_rows_i  = CNT_W'(rows);
      @(posedge clk);
      #1;
      bus_if.job_valid_i = 1'b0;
      act = obs();
      checks++;
      if ((act !== (IDLE_V | 11'h001)) || (bus_if.enable_cycles_o !== 32'(last_rows))) begin
         errors++;
         $display("FAIL reject rows=%0d: outputs got %b enc %0d want %b enc %0d", rows, act,
                  bus_if.enable_cycles_o, IDLE_V | 11'h001, last_rows);
      end
      @(posedge clk);
      #1;
      act = obs();
      checks++;
      if (act !== IDLE_V) begin
         errors++;
         $display("FAIL reject_after rows=%0d: outputs got %b want %b", rows, act, IDLE_V);
      end
      clear_inputs();
   endtask

   task automatic test_idle_abort();
      logic [10:0] act;
      bus_if.job_valid_i = 1'b1;
      bus_if.job_rows_i  = CNT_W'(3);
      bus_if.abort_i     = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
         bus_if.job_valid_i = 1'b0;
         bus_if.abort_i     = 1'b0;
         act = obs();
         checks++;
         if (act !== IDLE_V) begin
            errors++;
            $display("FAIL idle_abort slot %0d: outputs got %b want %b", n, act, IDLE_V);
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      logic [10:0] act;
      // slot s+3 lies inside WAIT_OUT for the directed schedule (s = 12)
      run_job(3, 1'b0, 1, 1'b0, 0, 3, -1, 15, "async_rst_job");
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < int'(LAT) + 6; n++) begin
         @(posedge clk);
         #1;
         act = obs();
         checks++;
         if ((act !== IDLE_V) || (bus_if.enable_cycles_o !== 32'd0)) begin
            errors++;
            $display("FAIL post_rst slot %0d: outputs got %b enc %0d want %b enc 0", n, act,
                     bus_if.enable_cycles_o, IDLE_V);
         end
      end
   endtask

   task automatic test_random();
      int rows;
      for (int j = 0; j < 8; j++) begin
         rows = (j == 0) ? int'(DEPTH) : ((j == 1) ? 1 : int'($urandom_range(DEPTH, 1)));
         run_job(rows, 1'($urandom_range(1, 0)), 0, 1'($urandom_range(1, 0)),
                 int'($urandom_range(3, 0)), int'($urandom_range(4, 1)),
                 ($urandom_range(3, 0) == 0) ? -2 : -1, -1, "random");
         repeat ($urandom_range(2, 0)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      run_job(3, 1'b0, 1, 1'b0, 0, 3, -1, -1, "basic");
      run_job(2, 1'b1, 1, 1'b0, 1, 2, -1, -1, "reuse");
      test_reject(0);
      test_reject(int'(DEPTH) + 1);
      // SIZE pushes one per cycle end at edge 5; SHIFT_W cycle 2 is slot 6
      run_job(2, 1'b0, 1, 1'b0, 0, 2, 6, -1, "abort_shift");
      test_idle_abort();
      run_job(2, 1'b0, 3, 1'b1, 2, 1, -1, -1, "gapped");
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hs_npu_mm_sequencer.md
Name: hs_npu_mm_sequencer

Overview:
Control FSM that sequences one matrix-multiply job through the NPU matrix-multiply unit (input/weight FIFOs, input/output gatekeepers, systolic array). It accepts a job descriptor, flushes FIFOs, gates weight and input loading by upstream producers, shifts weights into the array, then fires the input and output gatekeeper cascades with the correct skew. It reports completion when the last output column finishes.

Parameters:
SIZE, 8, systolic array dimension (rows = columns)
INPUT_FIFO_DEPTH, 10, depth of each input FIFO; upper bound on rows per job
ARRAY_LATENCY, 9, cycles from start_input_gatekeeper pulse to start_output_gatekeeper pulse (must be >= 2)
CNT_W, 16, width of row/cycle counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  sequencer can accept a job (high only in IDLE)
job_rows_i  in  CNT_W  number of input-matrix rows in this job
job_reuse_w_i  in  1  keep weights already in array; skip weight flush/load/shift
abort_i  in  1  abandon current job
weight_push_i  in  1  one weight row accepted by all weight FIFOs this cycle
input_push_i  in  1  one input row accepted by all input FIFOs this cycle
last_col_valid_i  in  1  valid_o[SIZE-1] of the matrix-multiply unit
weight_load_en_o  out  1  upstream may push weight rows
input_load_en_o  out  1  upstream may push input rows
flush_weight_fifos_o  out  1  one-cycle weight FIFO flush
flush_input_fifos_o  out  1  one-cycle input FIFO flush
enable_weights_o  out  1  weight FIFO pop / array weight shift
start_input_gatekeeper_o  out  1  one-cycle pulse
start_output_gatekeeper_o  out  1  one-cycle pulse
enable_cycles_o  out  32  gatekeeper enable-cycle count (uword), latched job_rows_i zero-extended
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse on job completion
err_o  out  1  one-cycle pulse on rejected job

Behaviour:
- Reset (async, rst=1): state IDLE; all pulse/enable outputs 0; enable_cycles_o 0; counters 0; job_ready_o 1 on reset release.
- All outputs registered (Moore); one-cycle latency from state change.
- States: IDLE, FLUSH, LOAD_W, SHIFT_W, LOAD_IN, START, WAIT_OUT, DRAIN, DONE.
- IDLE: on job_valid_i & job_ready_o: if job_rows_i==0 or >INPUT_FIFO_DEPTH -> err_o pulse, stay IDLE; else latch rows/reuse -> FLUSH.
- FLUSH (1 cycle): flush_input_fifos_o=1; flush_weight_fifos_o=1 unless reuse. Next: LOAD_IN if reuse else LOAD_W.
- LOAD_W: weight_load_en_o=1; count weight_push_i; at SIZE pushes -> SHIFT_W. Pushes while load_en low ignored.
- SHIFT_W: enable_weights_o=1 for exactly SIZE cycles -> LOAD_IN.
- LOAD_IN: input_load_en_o=1; count input_push_i; at latched rows -> START.
- START (1 cycle): start_input_gatekeeper_o=1; load wait counter ARRAY_LATENCY-1 -> WAIT_OUT.
- WAIT_OUT: decrement; at 0 pulse start_output_gatekeeper_o, -> DRAIN. Net pulse spacing exactly ARRAY_LATENCY cycles.
- DRAIN: wait for last_col_valid_i seen high then low (falling edge) -> DONE. Falling edge without prior high ignored.
- DONE (1 cycle): done_o=1 -> IDLE.
- abort_i in any non-IDLE state: next cycle both flushes=1 (one cycle), all enables/starts 0, -> IDLE; no done_o. abort_i in IDLE with job_valid_i: abort wins, job not accepted.
- Load enables deassert in the same cycle the final counted push is registered; the push that completes the count is accepted, later pushes are upstream protocol errors (not counted).
- Counters saturate at their terminal value; no wrap.

Decomposition:
- hs_npu_pkg: mm_seq_state_t enum; uword already present.
- Sub-module hs_npu_mm_seq_counter (loadable down-counter with zero flag), reused for weight count, shift count, input count, wait count.

Test Plan:
- SIZE=4, rows=3, reuse=0, one push/cycle: flush 1 cycle, 4 weight pushes, enable_weights 4 cycles, 3 input pushes, start_in pulse, start_out exactly ARRAY_LATENCY cycles later, last_col_valid high 3 cycles then low -> done_o one cycle later; enable_cycles_o=3.
- reuse=1, rows=2: flush_weight_fifos_o stays 0, no LOAD_W/SHIFT_W, enable_weights_o never high, done_o asserted.
- rows=0 then rows=11 (depth 10): err_o pulse each, busy_o stays 0, no flush.
- abort_i during SHIFT_W cycle 2: next cycle both flushes=1, enable_weights_o=0, then IDLE, job_ready_o=1, no done_o.
- Gapped pushes (weight_push_i every 3rd cycle) plus extra push after count: exactly SIZE counted, load_en low afterward.
- Async rst asserted mid-WAIT_OUT: outputs 0 immediately without clock edge, no start_output pulse after release.
